frame_buf_arb: RTL and testbench
================================

FRAME_BUF_ARB -- requirements
Module: frame_buf_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data bus.
REQ-002 Parameter ADDR_WIDTH, default 29, SHALL set the width of the word address.
REQ-003 Parameter BUF_SIZE, default 307200, SHALL set the words per frame region (640x480).
REQ-004 Parameter BASE0, default 2, SHALL set the first address of region 0. BASE1, default BASE0+BUF_SIZE, SHALL set the first address of region 1.
REQ-005 Parameter QUANTUM, default 16, SHALL set the maximum number of beats per grant.
REQ-006 Ports, as name / direction / width / meaning:
- clk, in, 1: the single clock. Reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high reset.
- ram_rdy, in, 1: memory calibrated.
- avl_ready, in, 1: memory accepts the current request.
- wr0_req / wr1_req, in, 1: camera 0 / 1 has a word to write.
- wr0_data / wr1_data, in, DATA_WIDTH: camera write data.
- wr0_ack / wr1_ack, out, 1: word consumed this cycle.
- rd_req, in, 1: display wants a word.
- rd_sel, in, 1: region the display reads; sampled at frame start.
- rd_ack, out, 1: read request accepted this cycle.
- avl_rdata, in, DATA_WIDTH: memory read data.
- avl_rdata_valid, in, 1: memory read data valid.
- rd_data, out, DATA_WIDTH: registered copy of avl_rdata.
- rd_data_valid, out, 1: registered copy of avl_rdata_valid.
- avl_addr, out, ADDR_WIDTH: request address.
- avl_wdata, out, DATA_WIDTH: write data.
- avl_write_req, out, 1: memory write request.
- avl_read_req, out, 1: memory read request.
- frame_done, out, 3: one-cycle pulse per port when its last frame word is accepted; bit 0 = wr0, bit 1 = wr1, bit 2 = rd.

Function
REQ-007 The state machine SHALL have exactly the states IDLE, SERV_W0, SERV_W1 and SERV_RD.
REQ-008 In IDLE with ram_rdy=1, the block SHALL enter the SERV state of the first requesting port, starting from the round-robin pointer in order W0->W1->RD->W0. With no requester it SHALL stay in IDLE.
REQ-009 In a SERV state, avl_write_req (for a writer) or avl_read_req (for the reader) SHALL equal that port's req AND avl_ready AND ram_rdy, combinationally. All other request outputs SHALL be 0.
REQ-010 A beat is accepted when the asserted request coincides with avl_ready=1; the matching ack SHALL equal that beat, in the same cycle.
REQ-011 The block SHALL never assert avl_write_req and avl_read_req together.
REQ-012 avl_addr and avl_wdata SHALL come from the granted port, and SHALL be 0 in IDLE.
REQ-013 A SERV state SHALL return to IDLE on any of: port req=0, QUANTUM beats accepted, last frame word accepted, or ram_rdy=0.
REQ-014 On return to IDLE, the round-robin pointer SHALL advance to the port after the one just served. This gives a one-cycle bubble between grants.
REQ-015 Each port SHALL keep its own address counter. wr0 runs BASE0..BASE0+BUF_SIZE-1 and wr1 runs BASE1..BASE1+BUF_SIZE-1. The counter SHALL increment only on an accepted beat.
REQ-016 On an accepted beat at the last address, the counter SHALL wrap to its base in the next cycle and the port's frame_done bit SHALL pulse for 1 cycle.
REQ-017 The read counter SHALL use region rd_sel as latched when the counter is at its base. A change of rd_sel mid-frame SHALL be ignored until the wrap.
REQ-018 rd_data and rd_data_valid SHALL be avl_rdata and avl_rdata_valid registered, with 1-cycle latency, independent of the grant.
REQ-019 The beat counter SHALL be $clog2(QUANTUM+1) bits wide and SHALL clear on every entry to a SERV state.

Reset
REQ-020 While reset=1 at a clk edge, the block SHALL set: state to IDLE, pointer to W0, all address counters to their base, latched rd_sel to 0, beat counter to 0, and frame_done, rd_data and rd_data_valid to 0.
REQ-021 Reset asserted mid-burst SHALL drop all requests and acks in the cycle after the reset edge. Partial-frame progress SHALL be discarded.

Configuration
REQ-022 With FRAME_BUF_ARB_RD_PRIO_EN defined, IDLE SHALL grant RD whenever rd_req=1, regardless of the pointer. The pointer SHALL still rotate between W0 and W1 only.
REQ-023 Without FRAME_BUF_ARB_RD_PRIO_EN, the block SHALL use pure three-way round-robin as in REQ-008.

Structure
REQ-024 A shared package frame_buf_pkg SHALL hold the state encoding, the port index constants (W0=0, W1=1, RD=2) and the default frame geometry constants.
REQ-025 A sub-module frame_buf_addr_gen (base/size parameters; inc, wrap and done outputs) SHALL be instantiated three times, once per port.

Verification
REQ-026 All three req held high with avl_ready=1 and QUANTUM=16 -> grants W0, W1, RD in turn, each for 16 acks, with one idle cycle between grants.
REQ-027 wr0_req high with the wr0 counter at BASE0+307199 -> accepted beat, avl_addr=307201, frame_done[0] pulses, next wr0 address=2.
REQ-028 avl_ready toggling 0/1 during SERV_W1 -> acks only on ready cycles, addresses contiguous, no skipped or duplicated address.
REQ-029 rd_sel=1 at frame start, then flipped to 0 at word 100 -> all reads of that frame in BASE1 region; next frame in BASE0 region.
REQ-030 reset pulsed for 1 cycle during a SERV_RD burst -> requests 0 in the next cycle, rd address back at BASE0, state IDLE.
REQ-031 With FRAME_BUF_ARB_RD_PRIO_EN defined and all req high -> pattern RD, W0, RD, W1; without the macro -> W0, W1, RD.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared definitions for the frame buffer arbiter: FSM state encoding,
// port index constants, default frame geometry and small mapping helpers.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERV_W0 = 2'd1,
    SERV_W1 = 2'd2,
    SERV_RD = 2'd3
  } state_t;

  typedef logic [1:0] port_t;

  localparam port_t W0 = 2'd0;
  localparam port_t W1 = 2'd1;
  localparam port_t RD = 2'd2;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 29;
  localparam int DEF_FRAME_W    = 640;
  localparam int DEF_FRAME_H    = 480;
  localparam int DEF_BUF_SIZE   = DEF_FRAME_W * DEF_FRAME_H;
  localparam int DEF_BASE0      = 2;
  localparam int DEF_QUANTUM    = 16;

  // Round-robin successor: W0 -> W1 -> RD -> W0.
  function automatic port_t next_port(input port_t p);
    case (p)
      W0:      return W1;
      W1:      return RD;
      default: return W0;
    endcase
  endfunction

  function automatic state_t serv_state(input port_t p);
    case (p)
      W1:      return SERV_W1;
      RD:      return SERV_RD;
      default: return SERV_W0;
    endcase
  endfunction

  function automatic port_t state_port(input state_t s);
    case (s)
      SERV_W1: return W1;
      SERV_RD: return RD;
      default: return W0;
    endcase
  endfunction

endpackage

// File: rtl/frame_buf_addr_gen.sv
// Per-port frame address counter. Walks BASE..BASE+SIZE-1 one step per
// accepted beat, wraps to BASE after the last word and pulses done for one
// cycle when that last word is taken.
module frame_buf_addr_gen #(
  parameter int ADDR_WIDTH = 29,
  parameter int BASE       = 2,
  parameter int SIZE       = 307200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wrap,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_OFS = ADDR_WIDTH'(SIZE - 1);

  logic [ADDR_WIDTH-1:0] ofs;

  assign wrap = (ofs == LAST_OFS);
  assign addr = ADDR_WIDTH'(BASE) + ofs;

  // Offset advances on each accepted beat; done marks the frame end.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      ofs  <= '0;
      done <= 1'b0;
    end else begin
      done <= inc & wrap;
      if (inc) ofs <= wrap ? '0 : ofs + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/frame_buf_arb.sv
// Frame buffer arbiter: two camera writers and one display reader share a
// single Avalon-style memory port. Grants are handed out one port at a time
// for up to QUANTUM beats, with a one-cycle IDLE bubble between grants.
// Optional macro FRAME_BUF_ARB_RD_PRIO_EN gives the reader priority in IDLE
// (writers alternate among themselves); without it arbitration is a plain
// three-way round-robin.
module frame_buf_arb
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BUF_SIZE   = DEF_BUF_SIZE,
  parameter int BASE0      = DEF_BASE0,
  parameter int BASE1      = BASE0 + BUF_SIZE,
  parameter int QUANTUM    = DEF_QUANTUM
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_rdy,
  input  logic                  avl_ready,
  input  logic                  wr0_req,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_ack,
  input  logic                  wr1_req,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_ack,
  input  logic                  rd_req,
  input  logic                  rd_sel,
  output logic                  rd_ack,
  input  logic [DATA_WIDTH-1:0] avl_rdata,
  input  logic                  avl_rdata_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic [DATA_WIDTH-1:0] avl_wdata,
  output logic                  avl_write_req,
  output logic                  avl_read_req,
  output logic [2:0]            frame_done
);

  localparam int BEAT_W = $clog2(QUANTUM + 1);

  state_t              state;
  port_t               ptr;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                sel_q;
`ifdef FRAME_BUF_ARB_RD_PRIO_EN
  logic                last_rd;
`endif

  logic                  w0_acc, w1_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] w0_addr, w1_addr, rd_ofs, rd_addr;
  logic                  w0_wrap, w1_wrap, rd_wrap;
  logic                  w0_done, w1_done, rd_done;
  logic                  rd_at_base, rd_sel_eff;

  logic                  cur_req, cur_acc, cur_wrap, leave;
  logic                  grant_valid;
  port_t                 grant_port;

  // A beat is accepted only when the granted port, memory and calibration agree.
  assign w0_acc = (state == SERV_W0) & wr0_req & avl_ready & ram_rdy;
  assign w1_acc = (state == SERV_W1) & wr1_req & avl_ready & ram_rdy;
  assign rd_acc = (state == SERV_RD) & rd_req  & avl_ready & ram_rdy;

  assign wr0_ack       = w0_acc;
  assign wr1_ack       = w1_acc;
  assign rd_ack        = rd_acc;
  assign avl_write_req = w0_acc | w1_acc;
  assign avl_read_req  = rd_acc;
  assign frame_done    = {rd_done, w1_done, w0_done};

  frame_buf_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (BASE0),
    .SIZE       (BUF_SIZE)
  ) u_addr_w0 (
    .clk   (clk),
    .reset (reset),
    .inc   (w0_acc),
    .addr  (w0_addr),
    .wrap  (w0_wrap),
    .done  (w0_done)
  );

  frame_buf_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (BASE1),
    .SIZE       (BUF_SIZE)
  ) u_addr_w1 (
    .clk   (clk),
    .reset (reset),
    .inc   (w1_acc),
    .addr  (w1_addr),
    .wrap  (w1_wrap),
    .done  (w1_done)
  );

  // The reader counts a plain offset; its region base is added below.
  frame_buf_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (0),
    .SIZE       (BUF_SIZE)
  ) u_addr_rd (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .addr  (rd_ofs),
    .wrap  (rd_wrap),
    .done  (rd_done)
  );

  // At frame start the live rd_sel is used; afterwards the latched copy.
  assign rd_at_base = (rd_ofs == '0);
  assign rd_sel_eff = rd_at_base ? rd_sel : sel_q;
  assign rd_addr    = rd_ofs + (rd_sel_eff ? ADDR_WIDTH'(BASE1) : ADDR_WIDTH'(BASE0));

  // Latch the display region while the read counter sits at its base.
  always_ff @(posedge clk) begin
    if (reset)           sel_q <= 1'b0;
    else if (rd_at_base) sel_q <= rd_sel;
  end

  // Read data is a plain one-cycle pipeline, independent of the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data       <= avl_rdata;
      rd_data_valid <= avl_rdata_valid;
    end
  end

  // Address and write-data mux for the granted port; zero when idle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    avl_addr  = '0;
    avl_wdata = '0;
    case (state)
      SERV_W0: begin
        avl_addr  = w0_addr;
        avl_wdata = wr0_data;
      end
      SERV_W1: begin
        avl_addr  = w1_addr;
        avl_wdata = wr1_data;
      end
      SERV_RD: avl_addr = rd_addr;
      default: ;
    endcase
  end

  // End-of-grant detection for the port currently served.
  always_comb begin
    cur_req  = 1'b0;
    cur_acc  = 1'b0;
    cur_wrap = 1'b0;
    case (state)
      SERV_W0: begin cur_req = wr0_req; cur_acc = w0_acc; cur_wrap = w0_wrap; end
      SERV_W1: begin cur_req = wr1_req; cur_acc = w1_acc; cur_wrap = w1_wrap; end
      SERV_RD: begin cur_req = rd_req;  cur_acc = rd_acc; cur_wrap = rd_wrap; end
      default: ;
    endcase
    leave = !cur_req || !ram_rdy ||
            (cur_acc && (cur_wrap || beat_cnt == BEAT_W'(QUANTUM - 1)));
  end

`ifdef FRAME_BUF_ARB_RD_PRIO_EN
  // Reader first; after a read grant a pending writer gets one turn.
  always_comb begin
    port_t first_w, second_w;
    logic  first_req, second_req;
    first_w     = (ptr == W1) ? W1 : W0;
    second_w    = (ptr == W1) ? W0 : W1;
    first_req   = (ptr == W1) ? wr1_req : wr0_req;
    second_req  = (ptr == W1) ? wr0_req : wr1_req;
    grant_valid = 1'b1;
    grant_port  = RD;
    if (rd_req && !(last_rd && (wr0_req || wr1_req))) grant_port = RD;
    else if (first_req)                               grant_port = first_w;
    else if (second_req)                              grant_port = second_w;
    else if (rd_req)                                  grant_port = RD;
    else                                              grant_valid = 1'b0;
  end
`else
  // Three-way round-robin scan starting at the pointer.
  always_comb begin
    logic [3:0] req_vec;
    port_t      p;
    req_vec     = {1'b0, rd_req, wr1_req, wr0_req};
    p           = ptr;
    grant_valid = 1'b0;
    grant_port  = W0;
    for (int i = 0; i < 3; i++) begin
      if (!grant_valid && req_vec[p]) begin
        grant_valid = 1'b1;
        grant_port  = p;
      end
      p = next_port(p);
    end
  end
`endif

  // Arbiter FSM: grant in IDLE, serve until the grant ends, rotate pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= W0;
      beat_cnt <= '0;
`ifdef FRAME_BUF_ARB_RD_PRIO_EN
      last_rd  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ram_rdy && grant_valid) begin
            state    <= serv_state(grant_port);
            beat_cnt <= '0;
          end
        end
        default: begin
          if (leave) begin
            state <= IDLE;
`ifdef FRAME_BUF_ARB_RD_PRIO_EN
            last_rd <= (state == SERV_RD);
            if (state == SERV_W0)      ptr <= W1;
            else if (state == SERV_W1) ptr <= W0;
`else
            ptr <= next_port(state_port(state));
`endif
          end else if (cur_acc) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_arb.sv
// Directed self-checking bench for frame_buf_arb (default build, macro
// FRAME_BUF_ARB_RD_PRIO_EN undefined). A short 40-word frame keeps wrap
// scenarios within a few hundred cycles: BASE0=2, BASE1=42, QUANTUM=16.
module tb_frame_buf_arb;

  localparam int DW = 32;
  localparam int AW = 29;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_rdy, avl_ready;
  logic          wr0_req, wr1_req, rd_req, rd_sel;
  logic [DW-1:0] wr0_data, wr1_data, avl_rdata;
  logic          avl_rdata_valid;
  logic          wr0_ack, wr1_ack, rd_ack;
  logic [DW-1:0] rd_data, avl_wdata;
  logic          rd_data_valid, avl_write_req, avl_read_req;
  logic [AW-1:0] avl_addr;
  logic [2:0]    frame_done;

  int n_checks = 0;
  int n_errors = 0;

  frame_buf_arb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BUF_SIZE   (40),
    .BASE0      (2),
    .QUANTUM    (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ram_rdy         (ram_rdy),
    .avl_ready       (avl_ready),
    .wr0_req         (wr0_req),
    .wr0_data        (wr0_data),
    .wr0_ack         (wr0_ack),
    .wr1_req         (wr1_req),
    .wr1_data        (wr1_data),
    .wr1_ack         (wr1_ack),
    .rd_req          (rd_req),
    .rd_sel          (rd_sel),
    .rd_ack          (rd_ack),
    .avl_rdata       (avl_rdata),
    .avl_rdata_valid (avl_rdata_valid),
    .rd_data         (rd_data),
    .rd_data_valid   (rd_data_valid),
    .avl_addr        (avl_addr),
    .avl_wdata       (avl_wdata),
    .avl_write_req   (avl_write_req),
    .avl_read_req    (avl_read_req),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, then release just after the second; DUT is in IDLE.
  task automatic do_reset();
    reset = 1'b1;
    wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0; rd_sel = 1'b0;
    avl_ready = 1'b1; ram_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_port, exp_addr, k, b, n;
    logic [2:0]  exp_ack;
    logic [31:0] exp_wdata;
    logic found, fd_seen;

    wr0_data = 32'h1000_0000;
    wr1_data = 32'h2000_0000;
    avl_rdata = 32'hdead_beef;
    avl_rdata_valid = 1'b1;

    // ---- reset state ----
    do_reset();
    #1;
    check("rst_addr",   avl_addr, 0);
    check("rst_wreq",   avl_write_req, 0);
    check("rst_rreq",   avl_read_req, 0);
    check("rst_acks",   {rd_ack, wr1_ack, wr0_ack}, 0);
    check("rst_fdone",  frame_done, 0);
    check("rst_rdata",  rd_data, 0);
    check("rst_rvalid", rd_data_valid, 0);
    tick();
    check("rdata_pipe",  rd_data, 32'hdead_beef);
    check("rvalid_pipe", rd_data_valid, 1);
    avl_rdata_valid = 1'b0;

    // ---- three-way round-robin, 16-beat quanta, one-cycle bubbles ----
    do_reset();
    wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1;
    for (int c = 0; c <= 52; c++) begin
      #1;
      exp_port = -1;
      exp_addr = 0;
      if (c > 0) begin
        k = (c - 1) / 17;
        b = (c - 1) % 17;
        if (b != 16) begin
          exp_port = k % 3;
          if (exp_port == 0)      exp_addr = (k == 0) ? 2 + b : 18 + b;
          else if (exp_port == 1) exp_addr = 42 + b;
          else                    exp_addr = 2 + b;
        end
      end
      exp_ack   = (exp_port < 0) ? 3'b000 : 3'(1 << exp_port);
      exp_wdata = (exp_port == 0) ? 32'h1000_0000 :
                  (exp_port == 1) ? 32'h2000_0000 : 32'h0;
      check($sformatf("rr_ack_c%0d", c),   {rd_ack, wr1_ack, wr0_ack}, exp_ack);
      check($sformatf("rr_addr_c%0d", c),  avl_addr, exp_addr);
      check($sformatf("rr_wdata_c%0d", c), avl_wdata, exp_wdata);
      check($sformatf("rr_excl_c%0d", c),  avl_write_req & avl_read_req, 0);
      tick();
    end

    // ---- wr0 frame wrap at the last address ----
    do_reset();
    wr1_req = 1'b0; rd_req = 1'b0; wr0_req = 1'b1;
    exp_addr = 2;
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      #1;
      if (wr0_ack) begin
        check($sformatf("wrap_addr_%0d", exp_addr), avl_addr, exp_addr);
        if (exp_addr == 41) found = 1'b1;
        else exp_addr++;
      end
      if (!found) tick();
    end
    if (!found) begin
      check("wrap_timeout", 0, 1);
    end else begin
      check("wrap_fd_early", frame_done, 3'b000);
      @(posedge clk); #2;
      check("wrap_fd_pulse", frame_done, 3'b001);
      check("wrap_bubble",   wr0_ack, 0);
      @(posedge clk); #2;
      check("wrap_fd_clear", frame_done, 3'b000);
      check("wrap_ack",      wr0_ack, 1);
      check("wrap_addr_base", avl_addr, 2);
      // Calibration loss blocks requests immediately.
      ram_rdy = 1'b0;
      #1;
      check("nordy_wreq", avl_write_req, 0);
      check("nordy_ack",  wr0_ack, 0);
    end

    // ---- avl_ready toggling during SERV_W1 ----
    do_reset();
    wr0_req = 1'b0; wr1_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      avl_ready = c[0];
      #1;
      if (wr1_ack) begin
        check($sformatf("tog_addr_%0d", n), avl_addr, 42 + n);
        n++;
      end
      if (!avl_ready) check($sformatf("tog_noack_c%0d", c), wr1_ack, 0);
      tick();
    end
    check("tog_ack_count", n, 20);
    avl_ready = 1'b1;

    // ---- rd_sel latched at frame start, ignored mid-frame ----
    do_reset();
    wr1_req = 1'b0; rd_sel = 1'b1; rd_req = 1'b1;
    n = 0;
    fd_seen = 1'b0;
    for (int cyc = 0; cyc < 150 && n < 41; cyc++) begin
      #1;
      if (frame_done[2]) fd_seen = 1'b1;
      if (rd_ack) begin
        check($sformatf("rsel_addr_%0d", n), avl_addr, (n < 40) ? 42 + n : 2);
        n++;
        if (n == 10) rd_sel = 1'b0;
      end
      if (n < 41) tick();
    end
    check("rsel_count", n, 41);
    check("rsel_fdone", fd_seen, 1);

    // ---- reset pulse during a SERV_RD burst ----
    do_reset();
    rd_sel = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("mid_rst_pre_ack",  rd_ack, 1);
    check("mid_rst_pre_addr", avl_addr, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("mid_rst_rreq", avl_read_req, 0);
    check("mid_rst_ack",  rd_ack, 0);
    check("mid_rst_addr", avl_addr, 0);
    @(posedge clk); #2;
    check("mid_rst_regrant", rd_ack, 1);
    check("mid_rst_base",    avl_addr, 2);
    rd_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
